// File: rtl/btb_pkg.sv
// Shared encodings, types and helpers for the BTB update-side controller.
package btb_pkg;

    localparam logic [2:0] OP_IDLE               = 3'b000;
    localparam logic [2:0] OP_VERIFY_FALLTHROUGH = 3'b010;
    localparam logic [2:0] OP_VERIFY_TARGET      = 3'b011;
    localparam logic [2:0] OP_INSERT_FALLTHROUGH = 3'b100;
    localparam logic [2:0] OP_INSERT_TARGET      = 3'b101;
    localparam logic [2:0] OP_CLEAR              = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_COMMIT,
        ST_CLEAR
    } btb_state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        taken;
        logic [15:0] target;
    } res_branch_t;

    function automatic logic [11:0] btb_tag(input logic [15:0] pc);
        return {1'b0, pc[15:5]};
    endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Small synchronous FIFO holding resolved branches between EX and the BTB update FSM.
module btb_update_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  res_branch_t              push_data,
    output res_branch_t              head,
    output res_branch_t              second,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    res_branch_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + PTR_W'(1)];
    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update initiator: buffers resolved branches, probes entries by tag, then issues
// one verify/insert op per branch, or a broadcast clear on flush.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [15:0]            res_pc,
    input  logic                   res_taken,
    input  logic [15:0]            res_target,
    input  logic                   flush_all,
    input  logic [NUM_ENTRIES-1:0] entry_update_hit,
    input  logic [NUM_ENTRIES-1:0] entry_empty,
    output logic [NUM_ENTRIES-1:0] entry_enable,
    output logic [2:0]             entry_op,
    output logic [11:0]            entry_in_pc,
    output logic [15:0]            entry_in_target,
    output logic                   busy,
    output logic [7:0]             insert_count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [NUM_ENTRIES-1:0] ONE_HOT0 = NUM_ENTRIES'(1);

    btb_state_t       state;
    logic [IDX_W-1:0] victim_ptr;

    res_branch_t      fifo_head;
    res_branch_t      fifo_second;
    res_branch_t      res_branch;
    res_branch_t      next_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             has_more;

    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic             empty_any;
    logic [IDX_W-1:0] empty_idx;
    logic [IDX_W-1:0] victim_idx;

    assign res_ready  = ~fifo_full & ~rst;
    assign push       = res_valid & res_ready & ~flush_all;
    assign pop        = (state == ST_COMMIT) & ~flush_all;
    assign busy       = (state != ST_IDLE) | ~fifo_empty;
    assign res_branch = '{pc: res_pc, taken: res_taken, target: res_target};

    btb_update_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_all),
        .push     (push),
        .pop      (pop),
        .push_data(res_branch),
        .head     (fifo_head),
        .second   (fifo_second),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // After the COMMIT pop the next head is either the second slot or a branch arriving now.
    always_comb begin
        next_head = fifo_second;
        if (fifo_count <= CNT_W'(1)) begin
            next_head = res_branch;
        end
        has_more = (fifo_count > CNT_W'(1)) | push;
    end

    // Descending scan so the lowest-index match wins.
    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        empty_any = 1'b0;
        empty_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (entry_update_hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (entry_empty[i]) begin
                empty_any = 1'b1;
                empty_idx = IDX_W'(i);
            end
        end
        victim_idx = empty_any ? empty_idx : victim_ptr;
    end

    // Outputs are loaded on the edge that enters each state, so every state sees them stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            victim_ptr      <= '0;
            entry_enable    <= '0;
            entry_op        <= OP_IDLE;
            entry_in_pc     <= '0;
            entry_in_target <= '0;
            insert_count    <= '0;
        end else if (flush_all) begin
            state           <= ST_CLEAR;
            victim_ptr      <= '0;
            entry_enable    <= '1;
            entry_op        <= OP_CLEAR;
            entry_in_pc     <= '0;
            entry_in_target <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    entry_enable <= '0;
                    entry_op     <= OP_IDLE;
                    if (!fifo_empty) begin
                        state           <= ST_PROBE;
                        entry_in_pc     <= btb_tag(fifo_head.pc);
                        entry_in_target <= fifo_head.target;
                    end
                end
                ST_PROBE: begin
                    state <= ST_COMMIT;
                    if (hit_any) begin
                        entry_enable <= ONE_HOT0 << hit_idx;
                        entry_op     <= fifo_head.taken ? OP_VERIFY_TARGET : OP_VERIFY_FALLTHROUGH;
                    end else if (fifo_head.taken) begin
                        entry_enable <= ONE_HOT0 << victim_idx;
                        entry_op     <= OP_INSERT_TARGET;
                        insert_count <= insert_count + 8'd1;
                        if (!empty_any) begin
                            victim_ptr <= victim_ptr + IDX_W'(1);
                        end
                    end else begin
                        entry_enable <= '0;
                        entry_op     <= OP_IDLE;
                    end
                end
                ST_COMMIT: begin
                    entry_enable <= '0;
                    entry_op     <= OP_IDLE;
                    if (has_more) begin
                        state           <= ST_PROBE;
                        entry_in_pc     <= btb_tag(next_head.pc);
                        entry_in_target <= next_head.target;
                    end else begin
                        state           <= ST_IDLE;
                        entry_in_pc     <= '0;
                        entry_in_target <= '0;
                    end
                end
                ST_CLEAR: begin
                    state        <= ST_IDLE;
                    entry_enable <= '0;
                    entry_op     <= OP_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    entry_enable <= '0;
                    entry_op     <= OP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios plus randomized branches
// scored against a transaction-level model of the entry array.
module tb_btb_update_ctrl;

    localparam int NE = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic        taken;
        logic [15:0] target;
    } br_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [15:0]   res_pc = '0;
    logic          res_taken = 1'b0;
    logic [15:0]   res_target = '0;
    logic          flush_all = 1'b0;
    logic [NE-1:0] entry_update_hit;
    logic [NE-1:0] entry_empty;
    logic [NE-1:0] entry_enable;
    logic [2:0]    entry_op;
    logic [11:0]   entry_in_pc;
    logic [15:0]   entry_in_target;
    logic          busy;
    logic [7:0]    insert_count;

    int checkCount = 0;
    int failCount  = 0;
    int cycle      = 0;

    // Entry array stub that responds to the DUT, and reference array owned by the model
    logic        stubValid [NE] = '{default: 1'b0};
    logic [11:0] stubTag   [NE] = '{default: 12'h0};
    logic        refValid  [NE] = '{default: 1'b0};
    logic [11:0] refTag    [NE] = '{default: 12'h0};
    int          refPtr     = 0;
    int          refInserts = 0;
    br_t         pend [$];

    logic [2:0]    logOp  [$];
    logic [NE-1:0] logEn  [$];
    logic [11:0]   logPc  [$];
    int            logCyc [$];

    bit            mOk;
    logic [2:0]    mOp;
    logic [NE-1:0] mEn;
    logic [11:0]   mPc;
    logic [15:0]   mTgt;

    int expIc = 0;

    btb_update_ctrl #(.NUM_ENTRIES(NE), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .flush_all       (flush_all),
        .entry_update_hit(entry_update_hit),
        .entry_empty     (entry_empty),
        .entry_enable    (entry_enable),
        .entry_op        (entry_op),
        .entry_in_pc     (entry_in_pc),
        .entry_in_target (entry_in_target),
        .busy            (busy),
        .insert_count    (insert_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    always_comb begin
        for (int i = 0; i < NE; i++) begin
            entry_update_hit[i] = stubValid[i] && (stubTag[i] == entry_in_pc);
            entry_empty[i]      = !stubValid[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Takes pending branches in order until one should produce an op
    task automatic modelNext(output bit ok, output logic [2:0] op, output logic [NE-1:0] en,
                             output logic [11:0] pc, output logic [15:0] tgt);
        ok = 0; op = 3'b000; en = '0; pc = '0; tgt = '0;
        while (!ok && pend.size() > 0) begin
            br_t         b;
            logic [11:0] t;
            int          hitIdx;
            int          victim;
            b = pend.pop_front();
            t = {1'b0, b.pc[15:5]};
            hitIdx = -1;
            victim = -1;
            for (int i = 0; i < NE; i++)
                if (refValid[i] && refTag[i] == t && hitIdx < 0) hitIdx = i;
            if (hitIdx >= 0) begin
                ok = 1;
                op = b.taken ? 3'b011 : 3'b010;
                en = NE'(1) << hitIdx;
            end else if (b.taken) begin
                for (int i = 0; i < NE; i++)
                    if (!refValid[i] && victim < 0) victim = i;
                if (victim < 0) begin
                    victim = refPtr;
                    refPtr = (refPtr + 1) % NE;
                end
                refValid[victim] = 1'b1;
                refTag[victim]   = t;
                refInserts++;
                ok = 1;
                op = 3'b101;
                en = NE'(1) << victim;
            end
            pc  = t;
            tgt = b.target;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (entry_op == 3'b111) begin
                checkOutput("clear_enable", 32'(entry_enable), 32'hF);
                for (int i = 0; i < NE; i++) stubValid[i] = 1'b0;
            end else if (entry_op != 3'b000 || entry_enable != '0) begin
                modelNext(mOk, mOp, mEn, mPc, mTgt);
                if (!mOk) begin
                    checkOutput("unexpected_op", 32'(entry_op), 32'h0);
                end else begin
                    checkOutput("op", 32'(entry_op), 32'(mOp));
                    checkOutput("enable", 32'(entry_enable), 32'(mEn));
                    checkOutput("in_pc", 32'(entry_in_pc), 32'(mPc));
                    checkOutput("in_target", 32'(entry_in_target), 32'(mTgt));
                end
                if (entry_op == 3'b101)
                    for (int i = 0; i < NE; i++)
                        if (entry_enable[i]) begin
                            stubValid[i] = 1'b1;
                            stubTag[i]   = entry_in_pc;
                        end
                logOp.push_back(entry_op);
                logEn.push_back(entry_enable);
                logPc.push_back(entry_in_pc);
                logCyc.push_back(cycle);
            end
            if (flush_all) begin
                pend.delete();
                for (int i = 0; i < NE; i++) refValid[i] = 1'b0;
                refPtr = 0;
            end else if (res_valid && res_ready) begin
                pend.push_back('{pc: res_pc, taken: res_taken, target: res_target});
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one branch and hold it until accepted; returns just after the accepting edge
    task automatic applyStimulus(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        int waitCycles;
        waitCycles = 0;
        res_pc = pc; res_taken = tk; res_target = tgt; res_valid = 1'b1;
        @(negedge clk);
        while (!res_ready && waitCycles < 50) begin
            waitCycles++;
            @(negedge clk);
        end
        if (!res_ready) checkOutput("accept_timeout", 32'(res_ready), 32'h1);
        nextCycle();
        res_valid = 1'b0;
    endtask

    task automatic doFlush();
        flush_all = 1'b1;
        nextCycle();
        flush_all = 1'b0;
        nextCycle();
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("idle_timeout", 32'(busy), 32'h0);
        nextCycle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int missing;
        bit dOk;
        logic [2:0] dOp;
        logic [NE-1:0] dEn;
        logic [11:0] dPc;
        logic [15:0] dTgt;
        logic [10:0] tagPool [6];
        logic [NE-1:0] expEn [5];
        tagPool = '{11'h005, 11'h0A1, 11'h3F0, 11'h091, 11'h777, 11'h100};
        expEn   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("ready_in_reset", 32'(res_ready), 32'h0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(res_ready), 32'h1);
        checkOutput("reset_op", 32'(entry_op), 32'h0);
        checkOutput("reset_enable", 32'(entry_enable), 32'h0);
        checkOutput("reset_in_pc", 32'(entry_in_pc), 32'h0);
        checkOutput("reset_in_target", 32'(entry_in_target), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_insert_count", 32'(insert_count), 32'h0);
        nextCycle();

        // Single taken miss with exact latency
        applyStimulus(16'h1234, 1'b1, 16'h2000);
        @(negedge clk);
        checkOutput("lat_idle_op", 32'(entry_op), 32'h0);
        checkOutput("lat_busy", 32'(busy), 32'h1);
        @(negedge clk);
        checkOutput("probe_in_pc", 32'(entry_in_pc), 32'h091);
        checkOutput("probe_op", 32'(entry_op), 32'h0);
        checkOutput("probe_enable", 32'(entry_enable), 32'h0);
        @(negedge clk);
        checkOutput("commit_op", 32'(entry_op), 32'h5);
        checkOutput("commit_enable", 32'(entry_enable), 32'h1);
        checkOutput("commit_in_pc", 32'(entry_in_pc), 32'h091);
        checkOutput("commit_in_target", 32'(entry_in_target), 32'h2000);
        checkOutput("commit_insert_count", 32'(insert_count), 32'h1);
        @(negedge clk);
        checkOutput("after_commit_op", 32'(entry_op), 32'h0);
        checkOutput("after_commit_busy", 32'(busy), 32'h0);
        expIc = 1;
        nextCycle();

        // Hit verify on entry 2
        doFlush();
        base = logOp.size();
        applyStimulus(16'h0020, 1'b1, 16'h1111);
        applyStimulus(16'h0040, 1'b1, 16'h2222);
        applyStimulus(16'h1234, 1'b1, 16'h3333);
        applyStimulus(16'h1234, 1'b0, 16'h4444);
        waitIdle();
        expIc += 3;
        checkOutput("hit_op_count", 32'(logOp.size() - base), 32'd4);
        if (logOp.size() == base + 4) begin
            checkOutput("hit_insert_enable", 32'(logEn[base+2]), 32'h4);
            checkOutput("hit_op", 32'(logOp[base+3]), 32'h2);
            checkOutput("hit_enable", 32'(logEn[base+3]), 32'h4);
            checkOutput("hit_in_pc", 32'(logPc[base+3]), 32'h091);
        end
        checkOutput("hit_insert_count", 32'(insert_count), 32'(expIc));

        // Replacement once all entries are valid
        doFlush();
        base = logOp.size();
        for (int k = 0; k < 4; k++) applyStimulus({11'(11'h010 + k), 5'h00}, 1'b1, 16'(16'h0100 + k));
        for (int k = 0; k < 5; k++) applyStimulus({11'(11'h020 + k), 5'h03}, 1'b1, 16'(16'h0200 + k));
        waitIdle();
        expIc += 9;
        checkOutput("repl_op_count", 32'(logOp.size() - base), 32'd9);
        if (logOp.size() == base + 9)
            for (int k = 0; k < 5; k++) begin
                checkOutput($sformatf("repl_victim%0d", k), 32'(logEn[base+4+k]), 32'(expEn[k]));
                checkOutput($sformatf("repl_op%0d", k), 32'(logOp[base+4+k]), 32'h5);
            end
        checkOutput("repl_insert_count", 32'(insert_count), 32'(expIc));

        // Backpressure with four back-to-back offers
        doFlush();
        base = logOp.size();
        applyStimulus(16'h0600, 1'b1, 16'hA000);
        applyStimulus(16'h0620, 1'b1, 16'hA001);
        checkOutput("bp_ready_full", 32'(res_ready), 32'h0);
        applyStimulus(16'h0640, 1'b1, 16'hA002);
        applyStimulus(16'h0660, 1'b1, 16'hA003);
        waitIdle();
        expIc += 4;
        checkOutput("bp_op_count", 32'(logOp.size() - base), 32'd4);
        if (logOp.size() == base + 4)
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("bp_order%0d", k), 32'(logEn[base+k]), 32'(1 << k));
                if (k > 0)
                    checkOutput($sformatf("bp_spacing%0d", k), 32'(logCyc[base+k] - logCyc[base+k-1]), 32'd2);
            end

        // Flush while COMMIT is showing its op
        applyStimulus(16'h1234, 1'b1, 16'h5555);
        nextCycle();
        nextCycle();
        flush_all = 1'b1;
        @(negedge clk);
        checkOutput("fc_commit_op", 32'(entry_op), 32'h5);
        checkOutput("fc_commit_enable", 32'(entry_enable), 32'h1);
        checkOutput("fc_busy", 32'(busy), 32'h1);
        expIc += 1;
        nextCycle();
        flush_all = 1'b0;
        base = logOp.size();
        @(negedge clk);
        checkOutput("fc_clear_op", 32'(entry_op), 32'h7);
        checkOutput("fc_clear_enable", 32'(entry_enable), 32'hF);
        @(negedge clk);
        checkOutput("fc_post_op", 32'(entry_op), 32'h0);
        checkOutput("fc_post_busy", 32'(busy), 32'h0);
        repeat (5) @(negedge clk);
        checkOutput("fc_no_more_ops", 32'(logOp.size() - base), 32'd0);
        checkOutput("fc_insert_count", 32'(insert_count), 32'(expIc));
        nextCycle();

        // Flush during PROBE abandons the update
        applyStimulus(16'h0060, 1'b1, 16'h6666);
        nextCycle();
        flush_all = 1'b1;
        nextCycle();
        flush_all = 1'b0;
        base = logOp.size();
        @(negedge clk);
        checkOutput("fp_clear_op", 32'(entry_op), 32'h7);
        waitIdle();
        checkOutput("fp_no_op", 32'(logOp.size() - base), 32'd0);
        checkOutput("fp_insert_count", 32'(insert_count), 32'(expIc));

        // Not-taken miss issues nothing
        base = logOp.size();
        applyStimulus(16'h0100, 1'b0, 16'h0001);
        waitIdle();
        checkOutput("nt_no_op", 32'(logOp.size() - base), 32'd0);
        checkOutput("nt_insert_count", 32'(insert_count), 32'(expIc));

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                flush_all  = 1'b1;
                res_valid  = 1'($urandom_range(0, 1));
                res_pc     = {tagPool[$urandom_range(0, 5)], 5'($urandom)};
                res_taken  = 1'b1;
                res_target = 16'($urandom);
                nextCycle();
                flush_all = 1'b0;
                res_valid = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) nextCycle();
                applyStimulus({tagPool[$urandom_range(0, 5)], 5'($urandom)},
                              1'($urandom_range(0, 3) != 0), 16'($urandom));
            end
        end
        waitIdle();
        missing = 0;
        while (pend.size() > 0) begin
            modelNext(dOk, dOp, dEn, dPc, dTgt);
            if (dOk) missing++;
        end
        checkOutput("rand_missing_ops", 32'(missing), 32'd0);
        checkOutput("rand_insert_count", 32'(insert_count), 32'(8'(refInserts)));

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
